bw_mac_acc: RTL and testbench
=============================

Name: bw_mac_acc

Overview:
- Sequential signed multiply-accumulate back end that sits directly downstream of the 4x4 Baugh-Wooley array multiplier.
- Consumes a burst of 8-bit signed products over a valid/ready handshake and accumulates them into a saturating ACC_W-bit two's-complement sum.
- Presents the result on a second valid/ready handshake.
- Used for short signed dot products (filter taps, small matrix rows).

Parameters:
- ACC_W, 12, accumulator/result width in bits (must be >= 8).
- LEN_W, 4, width of the burst-length field; max burst = 2^LEN_W - 1 products.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  synchronous active-low reset, sampled on rising clk
- start  input  1  begin a new burst; honoured only in IDLE
- len  input  LEN_W  number of products in burst, sampled with start (unsigned)
- in_valid  input  1  prod is valid
- in_ready  output  1  block accepts prod this cycle
- prod  input  8  signed product from multiplier (two's complement)
- out_valid  output  1  acc_out/sat valid
- out_ready  input  1  consumer takes result
- acc_out  output  ACC_W  signed accumulated sum
- sat  output  1  sticky: saturation occurred at least once during this burst

Behaviour:
- Reset (rst_n=0 at a clk edge): state=IDLE; acc=0, remaining count=0, sat=0, in_ready=0, out_valid=0, acc_out=0. Reset mid-burst abandons the burst with no partial result.
- IDLE:
  - in_ready=0, out_valid=0.
  - start=1 with len!=0: clear acc and sat, load count=len, go to ACC.
  - start=1 with len=0: clear acc and sat, go directly to DONE (result 0, sat=0).
- ACC:
  - in_ready=1.
  - On each in_valid&in_ready: acc <= satadd(acc, sext(prod)); count <= count-1.
  - If the accepted product is the last one (count==1), go to DONE next cycle.
  - in_valid=0 stalls indefinitely, holding state.
  - start is ignored.
- DONE:
  - out_valid=1, in_ready=0.
  - acc_out and sat are held stable while out_valid=1 and out_ready=0.
  - out_ready=1: go to IDLE next cycle.
  - start in the same cycle as the out handshake is ignored; it must be re-issued in IDLE.
- Arithmetic:
  - prod is sign-extended to ACC_W+1 bits and added to sign-extended acc.
  - If the result exceeds 2^(ACC_W-1)-1, clamp to that maximum; if below -2^(ACC_W-1), clamp to that minimum.
  - sat is set on any clamp and is never cleared within a burst.
  - Later products continue to be added from the clamped value (no wrap-around).
- Latency: out_valid rises exactly 1 cycle after the last product handshake.
  - Minimum start-to-out_valid latency is len+1 cycles.
  - For len=0 the latency is 1 cycle.
- acc_out is driven from the accumulator register; there is no combinational path from prod to any output.
- in_ready depends only on state, never on in_valid.

Decomposition:
- Shared package bw_pkg holds:
  - PROD_W=8;
  - the state enum {IDLE, ACC, DONE}, 2-bit encoding;
  - helper constants for signed max/min of a given width.
- The multiplier itself is not instantiated inside this block; the top level wires the multiplier's p output to prod.
- One sub-module is natural: sat_add (parameter W; inputs a[W-1:0], b[7:0] signed; outputs y[W-1:0], ovf). It is purely combinational and is also reusable by later accumulate stages.

Test Plan:
- Reset then idle: rst_n=0 for 2 cycles, then release -> in_ready=0, out_valid=0, acc_out=0, sat=0; pulse rst_n=0 mid-ACC -> all outputs return to reset values the next cycle.
- Basic burst: start, len=3; products 6, -56, 64 with continuous in_valid -> out_valid 1 cycle after third accept, acc_out=14, sat=0.
- Stalls: same burst as above with in_valid gaps of 2 cycles between products, then out_ready held low 3 cycles -> acc_out=14 held stable throughout, out_valid drops the cycle after out_ready=1.
- Positive saturation, ACC_W=8: len=3; products 64, 64, -10 -> clamps to 127 after the second product; final acc_out=117, sat=1.
- Negative saturation, ACC_W=8: len=3; products -56 x3 -> acc_out=-128 (0x80), sat=1.
- len=0 and ignored start: start with len=0 -> out_valid next cycle, acc_out=0, sat=0; start asserted during ACC and during DONE -> no effect on count or result.

Source files
------------

// File: rtl/bw_pkg.sv
// rtl/bw_pkg.sv - shared constants, state encoding and saturation limits for the Baugh-Wooley MAC back end
package bw_pkg;

  localparam int PROD_W = 8;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_ACC  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  typedef enum logic [1:0] {
    IDLE = ST_IDLE,
    ACC  = ST_ACC,
    DONE = ST_DONE
  } state_e;

  // Largest / smallest two's-complement value representable in w bits (w <= 31).
  function automatic int smax(input int w);
    return (1 << (w - 1)) - 1;
  endfunction

  function automatic int smin(input int w);
    return -(1 << (w - 1));
  endfunction

endpackage

// File: rtl/bw_mac_acc_sat_add.sv
// rtl/bw_mac_acc_sat_add.sv - combinational saturating add of an 8-bit signed product into a W-bit signed value
module sat_add
  import bw_pkg::*;
#(
  parameter int W = 12
) (
  input  logic [W-1:0]      a,
  input  logic [PROD_W-1:0] b,
  output logic [W-1:0]      y,
  output logic              ovf
);

  localparam logic [W-1:0] MAXV = W'(smax(W));
  localparam logic [W-1:0] MINV = W'(smin(W));

  logic [W:0] sum;

  // One guard bit is enough: a single 8-bit addend can push a W-bit value at most one bit over.
  assign sum = {a[W-1], a} + {{(W + 1 - PROD_W){b[PROD_W-1]}}, b};

  always_comb begin
    y   = sum[W-1:0];
    ovf = 1'b0;
    if (sum[W] != sum[W-1]) begin
      ovf = 1'b1;
      y   = sum[W] ? MINV : MAXV;
    end
  end

endmodule

// File: rtl/bw_mac_acc.sv
// rtl/bw_mac_acc.sv - burst signed multiply-accumulate with saturation and valid/ready in/out handshakes
module bw_mac_acc
  import bw_pkg::*;
#(
  parameter int ACC_W = 12,
  parameter int LEN_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [LEN_W-1:0]  len,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [PROD_W-1:0] prod,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  acc_out,
  output logic              sat
);

  state_e            state;
  logic [LEN_W-1:0]  cnt;
  logic [ACC_W-1:0]  acc;
  logic [ACC_W-1:0]  sum_y;
  logic              sum_ovf;

  sat_add #(.W(ACC_W)) u_sat_add (
    .a   (acc),
    .b   (prod),
    .y   (sum_y),
    .ovf (sum_ovf)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
      acc   <= '0;
      sat   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            acc <= '0;
            sat <= 1'b0;
            cnt <= len;
            state <= (len != '0) ? ACC : DONE;
          end
        end
        ACC: begin
          if (in_valid) begin
            acc <= sum_y;
            sat <= sat | sum_ovf;
            cnt <= cnt - 1'b1;
            if (cnt == LEN_W'(1)) state <= DONE;
          end
        end
        DONE: begin
          // start coinciding with the result handshake is dropped; it must be re-issued from IDLE.
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state == ACC);
  assign out_valid = (state == DONE);
  assign acc_out   = acc;

endmodule

// File: tb/tb_bw_mac_acc.sv
// tb/tb_bw_mac_acc.sv - scoreboard bench for bw_mac_acc at ACC_W=12 and ACC_W=8
module tb_bw_mac_acc;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [3:0]  len;
  logic        in_valid;
  logic [7:0]  prod;
  logic        out_ready;

  logic        in_ready12, out_valid12, sat12;
  logic [11:0] acc12;
  logic        in_ready8, out_valid8, sat8;
  logic [7:0]  acc8;

  int vectors = 0;
  int miscompares = 0;

  typedef struct {
    logic [11:0] a12;
    logic        s12;
    logic [7:0]  a8;
    logic        s8;
  } exp_t;

  exp_t sb[$];
  int   pq[$];

  always #5 clk = ~clk;

  bw_mac_acc #(.ACC_W(12), .LEN_W(4)) u_dut12 (
    .clk(clk), .rst_n(rst_n), .start(start), .len(len),
    .in_valid(in_valid), .in_ready(in_ready12), .prod(prod),
    .out_valid(out_valid12), .out_ready(out_ready),
    .acc_out(acc12), .sat(sat12)
  );

  bw_mac_acc #(.ACC_W(8), .LEN_W(4)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .start(start), .len(len),
    .in_valid(in_valid), .in_ready(in_ready8), .prod(prod),
    .out_valid(out_valid8), .out_ready(out_ready),
    .acc_out(acc8), .sat(sat8)
  );

  function automatic void model(input int w, output int acc, output bit s);
    int mx, mn;
    mx  = (1 << (w - 1)) - 1;
    mn  = -(1 << (w - 1));
    acc = 0;
    s   = 1'b0;
    foreach (pq[i]) begin
      acc = acc + pq[i];
      if (acc > mx) begin acc = mx; s = 1'b1; end
      if (acc < mn) begin acc = mn; s = 1'b1; end
    end
  endfunction

  task automatic push_expected();
    exp_t e;
    int   a;
    bit   s;
    model(12, a, s); e.a12 = a[11:0]; e.s12 = s;
    model(8,  a, s); e.a8  = a[7:0];  e.s8  = s;
    sb.push_back(e);
  endtask

  task automatic check_idle_outputs(input string name);
    vectors++;
    if (in_ready12 !== 1'b0 || out_valid12 !== 1'b0 || acc12 !== 12'h000 || sat12 !== 1'b0 ||
        in_ready8 !== 1'b0 || out_valid8 !== 1'b0 || acc8 !== 8'h00 || sat8 !== 1'b0) begin
      miscompares++;
      $display("FAIL %s: got rdy=%b/%b vld=%b/%b acc=%h/%h sat=%b/%b, want all 0",
               name, in_ready12, in_ready8, out_valid12, out_valid8, acc12, acc8, sat12, sat8);
    end
  endtask

  // Drives one burst from pq; gap = idle cycles before each product, hold = cycles out_ready stays low.
  task automatic run_burst(input string name, input int gap, input int hold, input bit noise);
    exp_t e;
    int   n;
    n = pq.size();
    push_expected();
    @(negedge clk);
    start = 1'b1;
    len   = 4'(n);
    @(negedge clk);
    start = noise;
    for (int i = 0; i < n; i++) begin
      for (int g = 0; g < gap; g++) begin
        in_valid = 1'b0;
        @(negedge clk);
      end
      vectors++;
      if (in_ready12 !== 1'b1 || in_ready8 !== 1'b1 || out_valid12 !== 1'b0) begin
        miscompares++;
        $display("FAIL %s in_ready[%0d]: got %b/%b vld=%b, want 1/1 vld=0",
                 name, i, in_ready12, in_ready8, out_valid12);
      end
      in_valid = 1'b1;
      prod     = 8'(pq[i]);
      @(negedge clk);
    end
    in_valid = 1'b0;
    out_ready = 1'b0;
    vectors++;
    if (out_valid12 !== 1'b1 || out_valid8 !== 1'b1 || in_ready12 !== 1'b0) begin
      miscompares++;
      $display("FAIL %s latency: got vld=%b/%b rdy=%b, want vld=1/1 rdy=0",
               name, out_valid12, out_valid8, in_ready12);
    end
    if (sb.size() == 0) begin
      vectors++;
      miscompares++;
      $display("FAIL %s scoreboard: got empty queue, want one entry", name);
    end else begin
      e = sb[0];
      for (int h = 0; h < hold; h++) begin
        @(negedge clk);
        vectors++;
        if (out_valid12 !== 1'b1 || acc12 !== e.a12 || sat12 !== e.s12) begin
          miscompares++;
          $display("FAIL %s hold[%0d]: got vld=%b acc=%h sat=%b, want vld=1 acc=%h sat=%b",
                   name, h, out_valid12, acc12, sat12, e.a12, e.s12);
        end
      end
      out_ready = 1'b1;
      e = sb.pop_front();
      vectors++;
      if (acc12 !== e.a12 || sat12 !== e.s12) begin
        miscompares++;
        $display("FAIL %s result12: got acc=%h sat=%b, want acc=%h sat=%b", name, acc12, sat12, e.a12, e.s12);
      end
      vectors++;
      if (acc8 !== e.a8 || sat8 !== e.s8) begin
        miscompares++;
        $display("FAIL %s result8: got acc=%h sat=%b, want acc=%h sat=%b", name, acc8, sat8, e.a8, e.s8);
      end
    end
    @(negedge clk);
    out_ready = 1'b0;
    start     = 1'b0;
    vectors++;
    if (out_valid12 !== 1'b0 || out_valid8 !== 1'b0 || in_ready12 !== 1'b0) begin
      miscompares++;
      $display("FAIL %s release: got vld=%b/%b rdy=%b, want 0/0 rdy=0", name, out_valid12, out_valid8, in_ready12);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_idle_outputs("reset_idle");
    start = 1'b1;
    len   = 4'd3;
    @(negedge clk);
    start    = 1'b0;
    in_valid = 1'b1;
    prod     = 8'd5;
    @(negedge clk);
    in_valid = 1'b0;
    rst_n    = 1'b0;
    @(negedge clk);
    check_idle_outputs("reset_mid_acc");
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic();
    pq = '{6, -56, 64};
    run_burst("basic", 0, 0, 1'b0);
  endtask

  task automatic test_stall();
    pq = '{6, -56, 64};
    run_burst("stall", 2, 3, 1'b0);
  endtask

  task automatic test_pos_sat();
    pq = '{64, 64, -10};
    run_burst("pos_sat", 0, 1, 1'b0);
  endtask

  task automatic test_neg_sat();
    pq = '{-56, -56, -56};
    run_burst("neg_sat", 1, 0, 1'b0);
  endtask

  task automatic test_len0();
    pq = {};
    run_burst("len0", 0, 1, 1'b0);
  endtask

  task automatic test_start_ignored();
    pq = '{6, -56, 64};
    run_burst("start_ignored", 1, 2, 1'b1);
  endtask

  task automatic test_back_to_back();
    for (int b = 0; b < 6; b++) begin
      int n;
      n  = (b == 0) ? 15 : int'($urandom_range(1, 15));
      pq = {};
      for (int i = 0; i < n; i++) pq.push_back(int'($urandom_range(0, 255)) - 128);
      run_burst("back_to_back", 0, 0, 1'(b & 1));
    end
  endtask

  initial begin
    rst_n     = 1'b0;
    start     = 1'b0;
    len       = 4'd0;
    in_valid  = 1'b0;
    prod      = 8'd0;
    out_ready = 1'b0;
    test_reset();
    test_basic();
    test_stall();
    test_pos_sat();
    test_neg_sat();
    test_len0();
    test_start_ignored();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
